// File: rtl/ubfifo_wr_sched.sv
// Producer-side scheduler for the unified-block FIFO: walks the picture in
// ubSize x ubSize blocks, gates each block on FIFO vacancy, then streams its words.
module ubfifo_wr_sched #(
    parameter int AW     = 8,
    parameter int ubSize = 64,
    parameter int unit   = 4
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          start,
    input  logic [12:0]   pic_width_in_luma_samples,
    input  logic [12:0]   pic_height_in_luma_samples,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          p_we_n,
    output logic [AW-1:0] p_waddr,
    output logic [AW:0]   p_pblk,
    input  logic [AW:0]   p_vc,
    output logic [12:0]   p_x1,
    output logic [12:0]   p_y1,
    output logic          busy,
    output logic          done
);

    localparam int          US = $clog2(unit);
    localparam logic [13:0] UB = 14'(ubSize);
    localparam logic [13:0] UM = 14'(unit - 1);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WAIT_VC,
        BURST,
        NEXT,
        FIN
    } state_t;

    state_t      state;
    logic [12:0] w;
    logic [12:0] h;
    logic [13:0] x0;
    logic [13:0] y0;
    logic [AW:0] cnt;

    logic [13:0] rem_w;
    logic [13:0] rem_h;
    logic [13:0] wblk;
    logic [13:0] hblk;
    logic [13:0] cw;
    logic [13:0] ch;
    logic [AW:0] cw_w;
    logic [AW:0] ch_w;
    logic [13:0] nx;
    logic [13:0] ny;
    logic [AW:0] cnt_nx;
    logic        accept;

    // Block geometry; x0/y0 are always inside the picture when these are used.
    always_comb begin
        rem_w  = {1'b0, w} - x0;
        rem_h  = {1'b0, h} - y0;
        wblk   = (rem_w < UB) ? rem_w : UB;
        hblk   = (rem_h < UB) ? rem_h : UB;
        cw     = (wblk + UM) >> US;
        ch     = (hblk + UM) >> US;
        cw_w   = (AW+1)'(cw);
        ch_w   = (AW+1)'(ch);
        nx     = x0 + UB;
        ny     = y0 + UB;
        cnt_nx = cnt + (AW+1)'(1);
    end

    // The write strobe follows the upstream handshake in the same cycle.
    assign accept = in_valid & in_ready;
    assign p_we_n = ~accept;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            p_waddr  <= '0;
            p_pblk   <= '0;
            p_x1     <= '0;
            p_y1     <= '0;
            w        <= '0;
            h        <= '0;
            x0       <= '0;
            y0       <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        w    <= pic_width_in_luma_samples;
                        h    <= pic_height_in_luma_samples;
                        x0   <= '0;
                        y0   <= '0;
                        busy <= 1'b1;
                        if (pic_width_in_luma_samples == '0 ||
                            pic_height_in_luma_samples == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    p_pblk <= cw_w * ch_w;
                    p_x1   <= 13'(x0 + wblk - 14'd1);
                    p_y1   <= 13'(y0 + hblk - 14'd1);
                    cnt    <= '0;
                    state  <= WAIT_VC;
                end
                WAIT_VC: begin
                    if (p_vc >= p_pblk) begin
                        state    <= BURST;
                        in_ready <= 1'b1;
                    end
                end
                BURST: begin
                    if (accept) begin
                        p_waddr <= p_waddr + AW'(1);
                        cnt     <= cnt_nx;
                        if (cnt_nx == p_pblk) begin
                            state    <= NEXT;
                            in_ready <= 1'b0;
                        end
                    end
                end
                NEXT: begin
                    if (nx >= {1'b0, w}) begin
                        x0 <= '0;
                        y0 <= ny;
                        if (ny >= {1'b0, h}) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        x0    <= nx;
                        state <= CALC;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ubfifo_wr_sched.sv
// Scoreboard bench for ubfifo_wr_sched: expected blocks are queued at start and
// popped as each burst opens; write addresses are tracked against a local counter.
`timescale 1ns/1ps
module tb_ubfifo_wr_sched;

    localparam int AW   = 8;
    localparam int UB   = 64;
    localparam int UNIT = 4;

    logic          clk;
    logic          arst_n;
    logic          start;
    logic [12:0]   pic_w;
    logic [12:0]   pic_h;
    logic          in_valid;
    logic          in_ready;
    logic          p_we_n;
    logic [AW-1:0] p_waddr;
    logic [AW:0]   p_pblk;
    logic [AW:0]   p_vc;
    logic [12:0]   p_x1;
    logic [12:0]   p_y1;
    logic          busy;
    logic          done;

    typedef struct {
        logic [AW:0] pblk;
        logic [12:0] x1;
        logic [12:0] y1;
    } blk_t;

    blk_t          exp_q[$];
    logic [AW-1:0] exp_waddr;
    int            n_cmp;
    int            n_err;

    ubfifo_wr_sched #(.AW(AW), .ubSize(UB), .unit(UNIT)) dut (
        .clk                        (clk),
        .arst_n                     (arst_n),
        .start                      (start),
        .pic_width_in_luma_samples  (pic_w),
        .pic_height_in_luma_samples (pic_h),
        .in_valid                   (in_valid),
        .in_ready                   (in_ready),
        .p_we_n                     (p_we_n),
        .p_waddr                    (p_waddr),
        .p_pblk                     (p_pblk),
        .p_vc                       (p_vc),
        .p_x1                       (p_x1),
        .p_y1                       (p_y1),
        .busy                       (busy),
        .done                       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one picture. gap: in_valid pattern 1,0,0,1; stall: cycles p_vc is held at 200;
    // restart: cycle index of a spurious start pulse (-1 for none).
    task automatic run_pic(input string name, input int w, input int h, input int gap,
                           input int stall, input int restart, output int done_cyc);
        blk_t e;
        blk_t cur;
        int   cyc;
        int   blk_writes;
        int   total;
        int   exp_total;
        int   ndone;
        logic prev_ready;
        bit   fin;
        exp_total = 0;
        total     = 0;
        ndone     = 0;
        done_cyc  = -1;
        cur.pblk  = '0;
        cur.x1    = '0;
        cur.y1    = '0;
        for (int y = 0; y < h; y += UB) begin
            for (int x = 0; x < w; x += UB) begin
                int wb;
                int hb;
                int pb;
                wb = (w - x < UB) ? w - x : UB;
                hb = (h - y < UB) ? h - y : UB;
                pb = ((wb + UNIT - 1) / UNIT) * ((hb + UNIT - 1) / UNIT);
                e.pblk = 9'(pb);
                e.x1   = 13'(x + wb - 1);
                e.y1   = 13'(y + hb - 1);
                exp_q.push_back(e);
                exp_total += pb;
            end
        end
        @(negedge clk);
        p_vc     = (stall > 0) ? 9'd200 : 9'd511;
        pic_w    = 13'(w);
        pic_h    = 13'(h);
        in_valid = 1'b1;
        start    = 1'b1;
        prev_ready = 1'b0;
        blk_writes = 0;
        fin = 1'b0;
        cyc = 0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            start = (restart >= 0 && cyc == restart);
            if (start) begin
                pic_w = 13'd16;
                pic_h = 13'd16;
            end
            in_valid = (gap != 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (stall > 0) p_vc = (cyc < stall) ? 9'd200 : 9'd256;
            #1;
            if (stall > 0 && cyc <= stall) begin
                n_cmp++;
                if (in_ready !== 1'b0 || p_we_n !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s stall_hold cyc=%0d: in_ready=%b p_we_n=%b want 0/1",
                             name, cyc, in_ready, p_we_n);
                end
            end
            if (stall > 0 && cyc == stall + 1) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s stall_release: in_ready=%b want 1", name, in_ready);
                end
            end
            if (in_ready === 1'b1 && prev_ready !== 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_block: got block x1=%0d y1=%0d want none",
                             name, p_x1, p_y1);
                end else begin
                    cur = exp_q.pop_front();
                    if (p_pblk !== cur.pblk || p_x1 !== cur.x1 || p_y1 !== cur.y1) begin
                        n_err++;
                        $display("FAIL %s block: got pblk=%0d x1=%0d y1=%0d want pblk=%0d x1=%0d y1=%0d",
                                 name, p_pblk, p_x1, p_y1, cur.pblk, cur.x1, cur.y1);
                    end
                end
                blk_writes = 0;
            end
            if (p_we_n === 1'b0) begin
                n_cmp++;
                if (p_waddr !== exp_waddr || in_valid !== 1'b1 || in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s write: got waddr=%0d in_valid=%b in_ready=%b want waddr=%0d with handshake",
                             name, p_waddr, in_valid, in_ready, exp_waddr);
                end
                exp_waddr++;
                blk_writes++;
                total++;
            end
            if (in_ready === 1'b0 && prev_ready === 1'b1) begin
                n_cmp++;
                if (9'(blk_writes) !== cur.pblk) begin
                    n_err++;
                    $display("FAIL %s block_writes: got %0d want %0d", name, blk_writes, cur.pblk);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
                fin = 1'b1;
            end
            prev_ready = in_ready;
            cyc++;
        end
        start = 1'b0;
        n_cmp++;
        if (!fin) begin
            n_err++;
            $display("FAIL %s timeout: got no done after %0d cycles want done", name, cyc);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: got busy=%b done=%b want 0/0", name, busy, done);
        end
        n_cmp++;
        if (exp_q.size() != 0 || total != exp_total || ndone != 1) begin
            n_err++;
            $display("FAIL %s totals: got writes=%0d blocks_left=%0d dones=%0d want %0d/0/1",
                     name, total, exp_q.size(), ndone, exp_total);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        arst_n   = 1'b0;
        start    = 1'b0;
        pic_w    = '0;
        pic_h    = '0;
        in_valid = 1'b0;
        p_vc     = 9'd511;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (p_we_n !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got we_n=%b ready=%b busy=%b done=%b want 1/0/0/0",
                     p_we_n, in_ready, busy, done);
        end
        n_cmp++;
        if (p_waddr !== '0 || p_pblk !== '0 || p_x1 !== '0 || p_y1 !== '0) begin
            n_err++;
            $display("FAIL reset_data: got waddr=%0d pblk=%0d x1=%0d y1=%0d want all 0",
                     p_waddr, p_pblk, p_x1, p_y1);
        end
        @(negedge clk);
        arst_n    = 1'b1;
        exp_waddr = '0;
    endtask

    task automatic test_full();
        int dc;
        run_pic("full", 128, 64, 0, 0, -1, dc);
        n_cmp++;
        if (p_waddr !== 8'd0) begin
            n_err++;
            $display("FAIL full_wrap: got waddr=%0d want 0", p_waddr);
        end
    endtask

    task automatic test_clip();
        int dc;
        run_pic("clip", 100, 70, 0, 0, -1, dc);
    endtask

    task automatic test_vc_stall();
        int dc;
        run_pic("vc_stall", 64, 64, 0, 20, -1, dc);
    endtask

    task automatic test_gaps();
        int dc;
        run_pic("gaps", 64, 8, 1, 0, -1, dc);
    endtask

    task automatic test_start_busy();
        int dc;
        run_pic("start_busy", 128, 64, 0, 0, 100, dc);
    endtask

    task automatic test_zero_dim();
        int dc;
        run_pic("zero_w", 0, 64, 0, 0, -1, dc);
        n_cmp++;
        if (dc < 0 || dc > 1) begin
            n_err++;
            $display("FAIL zero_w_latency: got done at cycle %0d want within 2 cycles of start", dc);
        end
        run_pic("zero_h", 40, 0, 0, 0, -1, dc);
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int dc;
        n = 0;
        @(negedge clk);
        p_vc     = 9'd511;
        in_valid = 1'b1;
        pic_w    = 13'd64;
        pic_h    = 13'd64;
        start    = 1'b1;
        for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (p_we_n === 1'b0) n++;
        end
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        n_cmp++;
        if (n != 10) begin
            n_err++;
            $display("FAIL mid_reset_writes: got %0d writes before reset want 10", n);
        end
        n_cmp++;
        if (p_we_n !== 1'b1 || busy !== 1'b0 || p_waddr !== '0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_state: got we_n=%b busy=%b waddr=%0d ready=%b want 1/0/0/0",
                     p_we_n, busy, p_waddr, in_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (p_we_n !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_hold: got we_n=%b want 1", p_we_n);
        end
        arst_n    = 1'b1;
        exp_waddr = '0;
        run_pic("replay", 64, 64, 0, 0, -1, dc);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_waddr = '0;
        test_reset();
        test_full();
        test_clip();
        test_vc_stall();
        test_gaps();
        test_start_busy();
        test_zero_dim();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ubfifo_wr_sched.md
Name: ubfifo_wr_sched

Overview:
Producer-side scheduler for the unified-block FIFO.
- On `start`, walks the picture in ubSize×ubSize unified blocks, in raster order.
- For each block it computes the clipped geometry and the word count, then gates the burst on FIFO vacancy.
- It then drives the FIFO write port, one unit-block word per accepted upstream beat.
- Sits between the upstream coefficient/pixel source and the FIFO producer port (p, p_waddr, p_we_n, p_pblk, p_vc, p_x1, p_y1).

Parameters:
- AW, 8: FIFO address width. Requires 2^(AW+1) > (ubSize/unit)^2.
- ubSize, 64: unified block size in pixels. Allowed values: 4, 8, 16, 32, 64.
- unit, 4: unit block size in pixels. Allowed values: 4, 8, 16, 32. Must be ≤ ubSize.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a picture. Sampled only in IDLE.
- pic_width_in_luma_samples  in  13  picture width. Latched on accepted start.
- pic_height_in_luma_samples  in  13  picture height. Latched on accepted start.
- in_valid  in  1  upstream word available
- in_ready  out  1  scheduler accepts the upstream word
- p_we_n  out  1  FIFO write enable, active low
- p_waddr  out  AW  FIFO write address
- p_pblk  out  AW+1  word count of the current block
- p_vc  in  AW+1  FIFO vacancy, in words
- p_x1  out  13  right pixel position of the current block
- p_y1  out  13  bottom pixel position of the current block
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the picture completes

Behaviour:
Reset values (arst_n low):
- state=IDLE; p_we_n=1; in_ready=0; busy=0; done=0.
- p_waddr=0; p_pblk=0; p_x1=0; p_y1=0.
- Internal x0=y0=0; word counter=0.

States: IDLE → CALC → WAIT_VC → BURST → NEXT → (CALC | FIN) → IDLE.

IDLE:
- On start=1, latch W and H, set x0=y0=0, go to CALC.
- If W==0 or H==0, go directly to FIN instead.
- While not in IDLE, start is ignored.

CALC (1 cycle). Compute and register:
- wblk = min(ubSize, W−x0); hblk = min(ubSize, H−y0).
- cw = ceil(wblk/unit); ch = ceil(hblk/unit).
- p_pblk = cw·ch, computed at full AW+1 width with no truncation.
- p_x1 = x0+wblk−1; p_y1 = y0+hblk−1.
- Clear the word counter.

WAIT_VC:
- Stay while p_vc < p_pblk.
- When p_vc ≥ p_pblk, go to BURST on the next edge.
- in_ready=0 in this state.

BURST:
- in_ready=1.
- A beat is accepted when in_valid && in_ready.
- On each accepted beat (same cycle):
  - p_we_n=0.
  - Present the current p_waddr.
  - Increment p_waddr modulo 2^AW on the next edge.
  - Increment the word counter.
- With no accepted beat: p_we_n=1 and the counter and address hold.
- After the beat that makes counter==p_pblk, go to NEXT. in_ready drops to 0 in that following cycle.

NEXT (1 cycle). Advance the block position:
- x0 += ubSize.
- If x0 ≥ W: x0=0 and y0 += ubSize.
- If y0 ≥ H: go to FIN; otherwise go to CALC.

FIN (1 cycle):
- done=1, then go to IDLE.
- busy is high through FIN.

Hold and persistence rules:
- p_pblk, p_x1, p_y1 are held stable from CALC through NEXT.
- p_waddr is never reset between blocks or pictures; it resets only via arst_n.
- Widths: x0/y0 are 14-bit internally, so that x0+ubSize cannot overflow.

Reset asserted mid-burst:
- Immediate return to reset values.
- No further p_we_n pulses.
- The partially written block is abandoned. FIFO recovery is the FIFO's own reset responsibility.

p_vc drop during BURST:
- Ignored. The vacancy check is performed only in WAIT_VC.

Test Plan:
1. Full-block picture (ub64/u4), start with W=128, H=64, p_vc=511, in_valid=1.
   - Required: two blocks, each p_pblk=256; (p_x1,p_y1)=(63,63) then (127,63).
   - Exactly 512 write pulses; done pulses once; p_waddr returns to 0 (AW=8 wrap).
2. Boundary clipping, W=100, H=70.
   - Required: p_pblk sequence 256, 144, 32, 18.
   - (p_x1,p_y1) sequence (63,63), (99,63), (63,69), (99,69).
3. Vacancy stall: hold p_vc=200 while p_pblk=256.
   - Required: stays in WAIT_VC with in_ready=0 and no writes.
   - Raise p_vc to 256 → burst starts 1 cycle later.
4. Upstream gaps: in_valid toggling 1,0,0,1 during BURST.
   - Required: p_we_n low only in the in_valid cycles; p_waddr advances only on those cycles.
5. Reset mid-burst after 10 writes of block 0.
   - Required: next cycle p_we_n=1, busy=0, p_waddr=0.
   - A new start replays block 0 from p_waddr=0.
6. start pulse while busy, and separately W=0.
   - start while busy: ignored, current picture unaffected.
   - W=0: done 2 cycles after start with zero writes.
